hazard_ctrl_mc: RTL and testbench

HAZARD_CTRL_MC -- requirements
Module: hazard_ctrl_mc

---
 rtl/hazard_ctrl_mc.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc.sv
// Hazard unit for a 5-stage pipeline: forwarding, load-use stall, branch flush and a
// multi-cycle data-memory wait FSM. Define HAZARD_PERF_CNT_EN to build the stall/flush counters.
module hazard_ctrl_mc #(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              MemAccessM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MemBusy,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt
);

  typedef enum logic {IDLE, WAIT} state_e;

  localparam bit         HAS_LAT = (MEM_LAT > 0);
  localparam logic [3:0] LAT_M1  = HAS_LAT ? 4'(MEM_LAT - 1) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mem_stall_raw;
  logic       lw_stall;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              wr_m,
    input logic [REG_AW-1:0] rd_m,
    input logic              wr_w,
    input logic [REG_AW-1:0] rd_w
  );
    if (wr_m && (rd_m != '0) && (rd_m == rs)) return 2'b10;
    if (wr_w && (rd_w != '0) && (rd_w == rs)) return 2'b01;
    return 2'b00;
  endfunction

  // The first stalled cycle is the IDLE cycle itself, so the counter starts at MEM_LAT-1.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_stall_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (HAS_LAT && MemAccessM) begin
          mem_stall_raw = 1'b1;
          state_d       = WAIT;
          cnt_d         = LAT_M1;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          mem_stall_raw = 1'b1;
          cnt_d         = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lw_stall = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    MemBusy   = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
      ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
      // A memory wait freezes the whole pipe; any branch flush waits until it releases.
      if (mem_stall_raw) begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallE  = 1'b1;
        StallM  = 1'b1;
        FlushW  = 1'b1;
        MemBusy = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE;
        FlushE = lw_stall | PCSrcE;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF)           stall_cnt_q <= stall_cnt_q + 32'd1;
      if (FlushE && PCSrcE) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed scoreboard bench for hazard_ctrl_mc; four instances with MEM_LAT = 0, 3, 2, 15
// share one stimulus stream. Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl_mc;
  localparam int AW = 5;

  // Output vector layout: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,MemBusy,FwdA,FwdB}
  localparam logic [11:0] Z    = 12'h000;
  localparam logic [11:0] MS   = 12'hF30;
  localparam logic [11:0] LU   = 12'hC40;
  localparam logic [11:0] LUPC = 12'hCC0;
  localparam logic [11:0] PC   = 12'h0C0;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, LoadE, PCSrcE, MemAccessM;

  logic [3:0]  sf, sd, se, sm, fd, fe, fw, mb;
  logic [1:0]  fa [4];
  logic [1:0]  fb [4];
  logic [31:0] sc [4];
  logic [31:0] fc [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          k;
    int          sel;
    logic [31:0] v;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    hazard_ctrl_mc #(
      .REG_AW (AW),
      .MEM_LAT((g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 2 : 15)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .Rs1D      (Rs1D),
      .Rs2D      (Rs2D),
      .Rs1E      (Rs1E),
      .Rs2E      (Rs2E),
      .RdE       (RdE),
      .RdM       (RdM),
      .RdW       (RdW),
      .RegWriteM (RegWriteM),
      .RegWriteW (RegWriteW),
      .LoadE     (LoadE),
      .PCSrcE    (PCSrcE),
      .MemAccessM(MemAccessM),
      .StallF    (sf[g]),
      .StallD    (sd[g]),
      .StallE    (se[g]),
      .StallM    (sm[g]),
      .FlushD    (fd[g]),
      .FlushE    (fe[g]),
      .FlushW    (fw[g]),
      .ForwardAE (fa[g]),
      .ForwardBE (fb[g]),
      .MemBusy   (mb[g]),
      .StallCnt  (sc[g]),
      .FlushCnt  (fc[g])
    );
  end

  function automatic logic [31:0] obs(input int k, input int sel);
    case (sel)
      0:       return {20'd0, sf[k], sd[k], se[k], sm[k], fd[k], fe[k], fw[k], mb[k], fa[k], fb[k]};
      1:       return sc[k];
      default: return fc[k];
    endcase
  endfunction

  task automatic push(input string tag, input int k, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.k = k; e.sel = sel; e.v = v;
    sb.push_back(e);
  endtask

  task automatic ctl(input string tag, input int k, input logic [11:0] v);
    push(tag, k, 0, {20'd0, v});
  endtask

  // Compare everything queued for this cycle away from the edge, then advance one cycle.
  task automatic tick();
    @(negedge clk);
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] o;
      e = sb.pop_front();
      o = obs(e.k, e.sel);
      checks++;
      assert (o === e.v) else begin
        errors++;
        $error("FAIL %s[inst%0d]: observed %h expected %h", e.tag, e.k, o, e.v);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    LoadE = 1'b0; PCSrcE = 1'b0; MemAccessM = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clear_in();
    MemAccessM = 1'b1; PCSrcE = 1'b1; LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    RegWriteM = 1'b1; RdM = 5'd3; Rs1E = 5'd3;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      ctl("rst_out", k, Z);
      push("rst_stallcnt", k, 1, 32'd0);
      push("rst_flushcnt", k, 2, 32'd0);
    end
    tick();

    rst = 1'b0;
    clear_in();
    for (int k = 0; k < 4; k++) ctl("post_rst", k, Z);
    tick();

    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd0;
    ctl("fwd_m_prio", 0, 12'h008);
    tick();
    RdM = 5'd0;
    ctl("fwd_rdm0", 0, 12'h004);
    tick();
    RdM = 5'd5; RegWriteM = 1'b0; Rs2E = 5'd5;
    ctl("fwd_w_both", 0, 12'h005);
    tick();
    RegWriteW = 1'b0;
    ctl("fwd_none", 0, Z);
    tick();

    clear_in();
    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    ctl("loaduse", 0, LU);
    tick();
    LoadE = 1'b0; RdE = 5'd0;
    ctl("loaduse_after", 0, Z);
    tick();
    LoadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
    ctl("load_rd0", 0, Z);
    tick();
    RdE = 5'd9; Rs1D = 5'd9; PCSrcE = 1'b1;
    ctl("lw_and_branch", 0, LUPC);
    tick();
    LoadE = 1'b0;
    ctl("branch_only", 0, PC);
    tick();
    clear_in();
    ctl("idle", 0, Z);
    push("cnt_stall_inst0", 0, 1, CNT_EN ? 32'd2 : 32'd0);
    push("cnt_flush_inst0", 0, 2, CNT_EN ? 32'd2 : 32'd0);
    tick();

    // Two back-to-back accesses on the MEM_LAT=3 instance.
    MemAccessM = 1'b1;
    for (int c = 0; c < 8; c++) begin
      ctl("memwait", 1, (c == 3 || c == 7) ? Z : MS);
      ctl("memwait_lat0", 0, Z);
      tick();
    end
    MemAccessM = 1'b0;
    ctl("memwait_done", 1, Z);
    tick();

    rst = 1'b1;
    ctl("rst_pulse", 2, Z);
    ctl("rst_pulse", 3, Z);
    tick();
    rst = 1'b0;
    ctl("rst_release", 2, Z);
    ctl("rst_release", 3, Z);
    tick();

    // Branch held during a MEM_LAT=2 wait.
    MemAccessM = 1'b1; PCSrcE = 1'b1;
    for (int c = 0; c < 3; c++) begin
      ctl("branch_wait", 2, (c == 2) ? PC : MS);
      ctl("branch_lat0", 0, PC);
      tick();
    end
    clear_in();
    ctl("branch_done", 2, Z);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset in the fourth WAIT cycle of a MEM_LAT=15 access.
    MemAccessM = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ctl("wait15", 3, MS);
      tick();
    end
    rst = 1'b1;
    ctl("wait15_rst", 3, Z);
    tick();
    rst = 1'b0;
    MemAccessM = 1'b0;
    ctl("wait15_after", 3, Z);
    push("wait15_stallcnt0", 3, 1, 32'd0);
    tick();

    MemAccessM = 1'b1;
    for (int c = 0; c < 16; c++) begin
      ctl("wait15_full", 3, (c < 15) ? MS : Z);
      tick();
    end
    MemAccessM = 1'b0;
    ctl("wait15_end", 3, Z);
    push("wait15_stallcnt", 3, 1, CNT_EN ? 32'd15 : 32'd0);
    push("wait15_flushcnt", 3, 2, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
